// File: rtl/calendar_pkg.sv
// Shared calendar definitions: edit-field codes, month lengths and leap-year rules
// used by the date, year, hour and minute counters.
package calendar_pkg;

    typedef enum logic [4:0] {
        STATE_DAY   = 5'd2,
        STATE_MONTH = 5'd3,
        STATE_YEAR  = 5'd4
    } edit_state_e;

    localparam logic [3:0] MONTHS_PER_YEAR = 4'd12;
    localparam logic [4:0] DAYS_LONG       = 5'd31;
    localparam logic [4:0] DAYS_SHORT      = 5'd30;
    localparam logic [4:0] DAYS_FEB        = 5'd28;
    localparam logic [4:0] DAYS_FEB_LEAP   = 5'd29;

    // Gregorian rule; year 0 is divisible by 400 and therefore leap.
    function automatic logic is_leap(input logic [14:0] year);
        return ((year % 15'd4 == 15'd0) && (year % 15'd100 != 15'd0)) ||
               (year % 15'd400 == 15'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [14:0] year);
        case (month)
            4'd2:                   return is_leap(year) ? DAYS_FEB_LEAP : DAYS_FEB;
            4'd4, 4'd6, 4'd9, 4'd11: return DAYS_SHORT;
            default:                return DAYS_LONG;
        endcase
    endfunction

endpackage

// File: rtl/fall_edge_det.sv
// Registered falling-edge detector: the flag rises one cycle after the input is
// first sampled low following a high sample.
module fall_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic fall_o
);

    logic prev_q;
    logic fall_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, which is what makes prev_q a true one-cycle delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= in_i;
            fall_q <= prev_q & ~in_i;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/date_counter.sv
// Day-of-month / month counter of the calendar chain: advances on the day carry,
// supports plus/minus editing, and pulses o_enable on the Dec 31 -> Jan 1 wrap.
module date_counter
    import calendar_pkg::*;
#(
    parameter logic [4:0] RESET_DAY   = 5'd1,
    parameter logic [3:0] RESET_MONTH = 4'd1,
    parameter logic [4:0] STATE_DAY   = calendar_pkg::STATE_DAY,
    parameter logic [4:0] STATE_MONTH = calendar_pkg::STATE_MONTH
) (
    input  logic        i_clk_0_001s,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic        is_modify,
    input  logic        i_plus,
    input  logic        i_minus,
    input  logic        i_enable,
    input  logic [14:0] i_year,
    output logic        o_enable,
    output logic [4:0]  o_day,
    output logic [3:0]  o_month
);

    logic carry_fall;
    logic plus_fall;
    logic minus_fall;

    fall_edge_det u_carry_det (.clk(i_clk_0_001s), .reset(reset), .in_i(i_enable), .fall_o(carry_fall));
    fall_edge_det u_plus_det  (.clk(i_clk_0_001s), .reset(reset), .in_i(i_plus),   .fall_o(plus_fall));
    fall_edge_det u_minus_det (.clk(i_clk_0_001s), .reset(reset), .in_i(i_minus),  .fall_o(minus_fall));

    logic [4:0] day_q, day_d;
    logic [3:0] month_q, month_d;
    logic       enable_q, enable_d;
    logic [4:0] dim_cur;
    logic [4:0] dim_new;
    logic [3:0] month_edit;
    logic       edit_en;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        day_d    = day_q;
        month_d  = month_q;
        enable_d = 1'b0;

        dim_cur    = days_in_month(month_q, i_year);
        month_edit = minus_fall ? ((month_q == 4'd1) ? MONTHS_PER_YEAR : month_q - 4'd1)
                                : ((month_q >= MONTHS_PER_YEAR) ? 4'd1 : month_q + 4'd1);
        dim_new    = days_in_month(month_edit, i_year);
        edit_en    = is_modify && (state == STATE_DAY || state == STATE_MONTH) &&
                     (minus_fall || plus_fall);

        // One action per cycle: carry, then minus, then plus, then year clamp.
        if (carry_fall) begin
            if (day_q < dim_cur) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d = 5'd1;
                if (month_q < MONTHS_PER_YEAR) begin
                    month_d = month_q + 4'd1;
                end else begin
                    month_d  = 4'd1;
                    enable_d = 1'b1;
                end
            end
        end else if (edit_en) begin
            if (state == STATE_MONTH) begin
                month_d = month_edit;
                if (day_q > dim_new) day_d = dim_new;
            end else if (minus_fall) begin
                day_d = (day_q <= 5'd1) ? dim_cur : day_q - 5'd1;
            end else begin
                day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
            end
        end else if (day_q > dim_cur) begin
            day_d = dim_cur;
        end
    end

    // NOTE: only a handful of flops and no memories here, so all state takes the
    // asynchronous reset; the carry pulse drops the instant reset asserts.
    always_ff @(posedge i_clk_0_001s or negedge reset) begin
        if (!reset) begin
            day_q    <= RESET_DAY;
            month_q  <= RESET_MONTH;
            enable_q <= 1'b0;
        end else begin
            day_q    <= day_d;
            month_q  <= month_d;
            enable_q <= enable_d;
        end
    end

    assign o_day    = day_q;
    assign o_month  = month_q;
    assign o_enable = enable_q;

endmodule
